// File: rtl/keypad_pkg.sv
// Shared key codes and the [row][col] -> code map for the 4x4 keypad.
// Also imported by the calculator's digit-entry FSM.
package keypad_pkg;

  localparam logic [4:0] KEY_NONE = 5'h1F;
  localparam logic [4:0] KEY_ADD  = 5'd10;
  localparam logic [4:0] KEY_SUB  = 5'd11;
  localparam logic [4:0] KEY_MUL  = 5'd12;
  localparam logic [4:0] KEY_DIV  = 5'd13;
  localparam logic [4:0] KEY_EQ   = 5'd14;
  localparam logic [4:0] KEY_MEM  = 5'd15;

  function automatic logic [4:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] code;
    case ({row, col})
      4'h0:    code = 5'd1;
      4'h1:    code = 5'd2;
      4'h2:    code = 5'd3;
      4'h3:    code = KEY_ADD;
      4'h4:    code = 5'd4;
      4'h5:    code = 5'd5;
      4'h6:    code = 5'd6;
      4'h7:    code = KEY_SUB;
      4'h8:    code = 5'd7;
      4'h9:    code = 5'd8;
      4'hA:    code = 5'd9;
      4'hB:    code = KEY_MUL;
      4'hC:    code = 5'd0;
      4'hD:    code = KEY_MEM;
      4'hE:    code = KEY_EQ;
      4'hF:    code = KEY_DIV;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Run-length debouncer over whole-scan results; emits the accepted code,
// a one-cycle strobe for each new non-idle code, and a held flag.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_done,
  input  logic [4:0] scan_result,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int RW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(DEBOUNCE_CNT);

  logic [RW-1:0] run_r;
  logic [RW-1:0] run_next_s;
  logic [4:0]    last_scan_r;
  logic [4:0]    key_code_r;
  logic          key_valid_r;
  logic          key_held_r;
  logic          accept_s;

  // Next run length: restart on a changed result, otherwise count up and saturate
  always_comb begin
    run_next_s = run_r;
    if (scan_result != last_scan_r) begin
      run_next_s = RW'(1);
    end else if (run_r == RUN_MAX) begin
      run_next_s = run_r;
    end else begin
      run_next_s = run_r + RW'(1);
    end
  end

  assign accept_s = scan_done && (run_next_s == RUN_MAX) && (scan_result != key_code_r);

  // Debounce state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r       <= {RW{1'b0}};
      last_scan_r <= KEY_NONE;
      key_code_r  <= KEY_NONE;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      if (scan_done) begin
        last_scan_r <= scan_result;
        run_r       <= run_next_s;
      end
      if (accept_s) begin
        key_code_r  <= scan_result;
        key_valid_r <= (scan_result != KEY_NONE);
        key_held_r  <= (scan_result != KEY_NONE);
      end else begin
        key_valid_r <= 1'b0;
      end
    end
  end

  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: drives one column low at a time, samples the
// synchronized rows at the end of each column, and resolves one code per scan.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] dwell_r;
  logic [1:0]    col_r;
  logic [3:0]    col_n_r;
  logic [3:0]    row_meta_r;
  logic [3:0]    row_sync_r;
  logic          last_d1_r;
  logic          last_d2_r;
  logic [1:0]    col_d1_r;
  logic [1:0]    col_d2_r;
  logic [1:0]    acc_cnt_r;
  logic [4:0]    acc_code_r;

  logic          dwell_end_s;
  logic          scan_done_s;
  logic [1:0]    col_next_s;
  logic [2:0]    col_cnt_s;
  logic [2:0]    sum_s;
  logic [1:0]    new_cnt_s;
  logic [4:0]    col_code_s;
  logic [4:0]    new_code_s;
  logic [4:0]    scan_result_s;

  assign dwell_end_s = (dwell_r == DW'(SCAN_DIV - 1));
  assign col_next_s  = col_r + 2'd1;
  assign scan_done_s = last_d2_r && (col_d2_r == 2'd3);

  // Dwell counter and one-hot active-low column drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_r <= {DW{1'b0}};
      col_r   <= 2'd0;
      col_n_r <= 4'b1110;
    end else if (dwell_end_s) begin
      dwell_r <= {DW{1'b0}};
      col_r   <= col_next_s;
      col_n_r <= ~(4'b0001 << col_next_s);
    end else begin
      dwell_r <= dwell_r + DW'(1);
    end
  end

  // Row synchronizer, with the sample strobe and column delayed to stay aligned to it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
      last_d1_r  <= 1'b0;
      last_d2_r  <= 1'b0;
      col_d1_r   <= 2'd0;
      col_d2_r   <= 2'd0;
    end else begin
      row_meta_r <= row_n;
      row_sync_r <= row_meta_r;
      last_d1_r  <= dwell_end_s;
      last_d2_r  <= last_d1_r;
      col_d1_r   <= col_r;
      col_d2_r   <= col_d1_r;
    end
  end

  // Fold this column's pressed rows into the running per-scan count and code
  always_comb begin
    col_cnt_s  = 3'd0;
    col_code_s = KEY_NONE;
    for (int r = 0; r < 4; r++) begin
      col_cnt_s  = col_cnt_s + {2'b00, ~row_sync_r[r]};
      col_code_s = row_sync_r[r] ? col_code_s : key_map(2'(r), col_d2_r);
    end
    sum_s         = {1'b0, acc_cnt_r} + col_cnt_s;
    new_cnt_s     = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    new_code_s    = (col_cnt_s != 3'd0) ? col_code_s : acc_code_r;
    scan_result_s = (new_cnt_s == 2'd1) ? new_code_s : KEY_NONE;
  end

  // Per-scan accumulator, cleared once the scan result has been handed on
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= KEY_NONE;
    end else if (scan_done_s) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= KEY_NONE;
    end else if (last_d2_r) begin
      acc_cnt_r  <= new_cnt_s;
      acc_code_r <= new_code_s;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .scan_done   (scan_done_s),
    .scan_result (scan_result_s),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held)
  );

  assign col_n = col_n_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: scan-level keypad stimulus, a history-based
// reference model, and a monitor that checks every key_valid strobe and column drive.
module tb_keypad_scanner;

  localparam int SCAN = 16;  // 4 columns x SCAN_DIV(4)
  localparam int DB   = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = 16'h0000;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  typedef struct {
    logic [4:0] code;
    int         cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] stim[$];
  logic [4:0]  hist[$];
  logic [4:0]  mcode;
  int          layout[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a pressed key sits on a driven column
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Monitor: column rotation every cycle, and every key_valid strobe against the queue
  always @(negedge clk) begin
    logic [3:0] ecol;
    ecol = ~(4'b0001 << ((cyc / 4) % 4));
    checks++;
    if (col_n !== ecol) begin
      errors++;
      $display("FAIL col_n cyc %0d actual %b expected %b", cyc, col_n, ecol);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse code %0d expected at cyc %0d", exp_q[0].code, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc %0d code %0d expected none", cyc, key_code);
      end else begin
        if (exp_q[0].cyc != cyc || key_code !== exp_q[0].code) begin
          errors++;
          $display("FAIL pulse cyc %0d code %0d expected cyc %0d code %0d",
                   cyc, key_code, exp_q[0].cyc, exp_q[0].code);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_cyc(input int t);
    int n;
    n = 0;
    while (cyc != t && n < 4 * SCAN) begin
      @(negedge clk);
      n++;
    end
    if (cyc != t) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc actual %0d expected %0d", cyc, t);
    end
  endtask

  function automatic logic [15:0] k(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  function automatic logic [4:0] scan_of(input logic [15:0] m);
    logic [4:0] res;
    res = 5'h1F;
    if ($countones(m) == 1) begin
      for (int i = 0; i < 16; i++) if (m[i]) res = 5'(layout[i]);
    end
    return res;
  endfunction

  // Reference: a code is accepted once the last DB scan results agree and differ from it
  task automatic model_scan(input logic [15:0] m, input int s);
    logic [4:0] res;
    int n;
    res = scan_of(m);
    hist.push_back(res);
    n = hist.size();
    if (n >= DB && hist[n-1] == hist[n-2] && hist[n-2] == hist[n-3] && res != mcode) begin
      mcode = res;
      if (res != 5'h1F) exp_q.push_back('{code: res, cyc: SCAN * s + 18});
    end
  endtask

  task automatic run_episode(input string name);
    int n;
    n = stim.size();
    reset_n = 1'b0;
    #1;
    chk({name, "_rst_code"}, key_code, 31);
    chk({name, "_rst_valid"}, key_valid, 0);
    chk({name, "_rst_held"}, key_held, 0);
    chk({name, "_rst_col"}, col_n, 14);
    keys = stim[0];
    hist.delete();
    mcode = 5'h1F;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < n; s++) begin
      if (s > 0) begin
        wait_cyc(SCAN * s);
        keys = stim[s];
      end
      wait_cyc(SCAN * s + 8);
      chk({name, "_code"}, key_code, mcode);
      chk({name, "_held"}, key_held, (mcode != 5'h1F) ? 1 : 0);
      model_scan(stim[s], s);
    end
    wait_cyc(SCAN * n + 8);
    chk({name, "_final_code"}, key_code, mcode);
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    stim.delete();
  endtask

  initial begin
    logic [15:0] cur;
    int k1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) stim.push_back(16'h0000);
    run_episode("idle");

    for (int i = 0; i < 6; i++) stim.push_back(k(1, 1));
    for (int i = 0; i < 6; i++) stim.push_back(16'h0000);
    run_episode("press_release");

    for (int i = 0; i < 8; i++) stim.push_back((i % 2 == 0) ? k(0, 3) : 16'h0000);
    for (int i = 0; i < 6; i++) stim.push_back(k(0, 3));
    run_episode("bounce");

    for (int i = 0; i < 6; i++) stim.push_back(k(0, 0) | k(0, 1));
    for (int i = 0; i < 6; i++) stim.push_back(k(0, 0));
    run_episode("chord");

    for (int i = 0; i < 5; i++) stim.push_back(k(3, 2));
    for (int i = 0; i < 5; i++) stim.push_back(k(3, 1));
    run_episode("switch");

    for (int i = 0; i < 5; i++) stim.push_back(k(2, 2));
    run_episode("before_reset");
    for (int i = 0; i < 5; i++) stim.push_back(k(2, 2));
    run_episode("after_reset");

    cur = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        k1 = $urandom_range(0, 15);
        case ($urandom_range(0, 2))
          0:       cur = 16'h0000;
          1:       cur = 16'(1) << k1;
          default: cur = (16'(1) << k1) | (16'(1) << ((k1 + $urandom_range(1, 15)) % 16));
        endcase
      end
      stim.push_back(cur);
    end
    run_episode("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
